// File: rtl/sin_pkg.sv
`default_nettype none
// ============================================================================
// Module : sin_pkg
// Brief  : Shared constants and state encoding for the sin phase generator.
// Rev    : 1.0
// ============================================================================
package sin_pkg;

  localparam logic [23:0] HALF_PI_Q = 24'hC90FDB;  // round(pi/2 * 2^23)
  localparam int          EXP_W     = 8;
  localparam int          MANT_W    = 23;
  localparam int          BIAS      = 127;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FOLD = 3'd1,
    S_MULT = 3'd2,
    S_NORM = 3'd3,
    S_PACK = 3'd4,
    S_WAIT = 3'd5,
    S_OUT  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fix2float_norm.sv
`default_nettype none
// ============================================================================
// Module : fix2float_norm
// Brief  : Iterative leading-one normaliser, one left shift per cycle.
// Rev    : 1.0
// ============================================================================
module fix2float_norm
  import sin_pkg::*;
#(
  parameter int IN_W    = 47,
  parameter int EXP_OFS = 45
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IN_W-1:0]   value,
  output logic              done,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out
);

  localparam int CNT_W   = $clog2(IN_W);
  localparam int EXP_TOP = BIAS + IN_W - 1 - EXP_OFS;

  logic [IN_W-1:0]  r_val;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  // start must never be raised with a zero value; the caller filters that case
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_val    <= value;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_val[IN_W-1]) begin
        r_active <= 1'b0;
      end else begin
        r_val <= r_val << 1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign done     = r_active & r_val[IN_W-1];
  assign exp_out  = EXP_W'(EXP_TOP) - EXP_W'(r_cnt);
  assign mant_out = r_val[IN_W-2 -: MANT_W];

endmodule
`default_nettype wire

// File: rtl/sin_phase_gen.sv
`default_nettype none
// ============================================================================
// Module : sin_phase_gen
// Brief  : Phase accumulator, quadrant fold and sequencer for the sin unit.
// Rev    : 1.0
// ============================================================================
module sin_phase_gen
  import sin_pkg::*;
#(
  parameter int         PHASE_W = 24,
  parameter logic [3:0] PREC    = 4'h7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] freq_inc,
  output logic [PHASE_W-1:0] phase_out,
  output logic [31:0]        sin_theta,
  output logic [3:0]         sin_prec,
  output logic               sin_reset,
  input  logic [31:0]        sin_result,
  input  logic               sin_done,
  output logic [31:0]        sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int F_W  = PHASE_W - 2;
  localparam int FP_W = PHASE_W - 1;
  // f' carries F_W fraction bits of a quarter turn, HALF_PI_Q carries 23
  localparam int M_W  = FP_W + 24;
  localparam logic [FP_W-1:0] QUARTER = {1'b1, {F_W{1'b0}}};

  state_t             r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_work;
  logic               r_qsign;
  logic [FP_W-1:0]    r_fprime;
  logic               r_mzero;
  logic               r_first;
  logic [31:0]        r_theta;
  logic               r_sin_reset;
  logic [31:0]        r_sample;
  logic               r_valid;
  logic               r_busy;
  logic               r_overrun;

  logic [F_W-1:0]    w_f;
  logic [FP_W-1:0]   w_fprime;
  logic [M_W-1:0]    w_m;
  logic              w_norm_start;
  logic              w_norm_done;
  logic [EXP_W-1:0]  w_exp;
  logic [MANT_W-1:0] w_mant;

  assign w_f          = r_work[F_W-1:0];
  assign w_fprime     = r_work[PHASE_W-2] ? (QUARTER - {1'b0, w_f}) : {1'b0, w_f};
  assign w_m          = M_W'(r_fprime) * M_W'(HALF_PI_Q);
  assign w_norm_start = (r_state == S_MULT) && (w_m != '0);

  // The normaliser's shift register is the registered copy of M
  fix2float_norm #(
    .IN_W    (M_W),
    .EXP_OFS (PHASE_W + 21)
  ) u_norm (
    .clk      (clk),
    .reset    (reset),
    .start    (w_norm_start),
    .value    (w_m),
    .done     (w_norm_done),
    .exp_out  (w_exp),
    .mant_out (w_mant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_work      <= '0;
      r_qsign     <= 1'b0;
      r_fprime    <= '0;
      r_mzero     <= 1'b0;
      r_first     <= 1'b0;
      r_theta     <= '0;
      r_sin_reset <= 1'b1;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= sample_tick && (r_state != S_IDLE);
      if (sample_tick) begin
        r_phase <= r_phase + freq_inc;
      end
      case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_work  <= r_phase;
            r_busy  <= 1'b1;
            r_state <= S_FOLD;
          end
        end
        S_FOLD: begin
          r_qsign  <= r_work[PHASE_W-1];
          r_fprime <= w_fprime;
          r_state  <= S_MULT;
        end
        S_MULT: begin
          r_mzero <= (w_m == '0);
          r_state <= (w_m == '0) ? S_PACK : S_NORM;
        end
        S_NORM: begin
          if (w_norm_done) begin
            r_state <= S_PACK;
          end
        end
        S_PACK: begin
          r_theta     <= r_mzero ? 32'h0 : {1'b0, w_exp, w_mant};
          r_sin_reset <= 1'b0;
          r_first     <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_first <= 1'b0;
          // done may still be high from the previous operation on the first cycle
          if (!r_first && sin_done) begin
            r_sample    <= (sin_result[30:0] == '0) ? 32'h0
                         : {sin_result[31] ^ r_qsign, sin_result[30:0]};
            r_valid     <= 1'b1;
            r_sin_reset <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_sin_reset <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign phase_out    = r_phase;
  assign sin_theta    = r_theta;
  assign sin_prec     = PREC;
  assign sin_reset    = r_sin_reset;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sin_phase_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_sin_phase_gen
// Brief  : Scoreboard bench for sin_phase_gen with a behavioural sin-unit stub.
// Rev    : 1.0
// ============================================================================
module tb_sin_phase_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic [23:0] freq_inc = '0;
  logic [23:0] phase_out;
  logic [31:0] sin_theta;
  logic [3:0]  sin_prec;
  logic        sin_reset;
  logic [31:0] sin_result;
  logic        sin_done;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  sin_phase_gen #(.PHASE_W(24), .PREC(4'hA)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .freq_inc     (freq_inc),
    .phase_out    (phase_out),
    .sin_theta    (sin_theta),
    .sin_prec     (sin_prec),
    .sin_reset    (sin_reset),
    .sin_result   (sin_result),
    .sin_done     (sin_done),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Sin-unit stub: exact results for the angles used, identity (sin x ~ x) otherwise
  int stub_lat   = 3;
  bit stub_stale = 1'b0;
  int stub_cnt;

  function automatic logic [31:0] sin_model(input logic [31:0] th);
    case (th)
      32'h00000000: return 32'h00000000;
      32'h3FC90FDB: return 32'h3F800000;
      32'h3F490FDB: return 32'h3F3504F3;
      default:      return th;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sin_done   <= 1'b0;
      sin_result <= '0;
      stub_cnt   <= 0;
    end else if (sin_reset) begin
      stub_cnt <= 0;
      if (stub_stale) begin
        sin_done   <= 1'b1;
        sin_result <= 32'h40490FDB;
      end else begin
        sin_done <= 1'b0;
      end
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt >= stub_lat) begin
        sin_done   <= 1'b1;
        sin_result <= sin_model(sin_theta);
      end else begin
        sin_done <= 1'b0;
      end
    end
  end

  logic [31:0] exp_theta_q[$];
  logic [31:0] exp_sample_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: theta checked when the sin unit is released, samples on sample_valid
  logic prev_sr = 1'b1;
  always @(negedge clk) begin
    if (reset) begin
      if (prev_sr && !sin_reset) begin
        if (exp_theta_q.size() == 0) fail_now("theta_unexpected");
        else check("theta", sin_theta, exp_theta_q.pop_front());
      end
      if (sample_valid) begin
        if (exp_sample_q.size() == 0) fail_now("sample_unexpected");
        else check("sample", {sample_out[31:3], 3'b0}, exp_sample_q.pop_front() & 32'hFFFF_FFF8);
      end
    end
    prev_sr = sin_reset;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("busy_timeout");
    @(negedge clk);
  endtask

  task automatic tick(input logic [31:0] th, input logic [31:0] smp, input bit push_s);
    wait_idle();
    exp_theta_q.push_back(th);
    if (push_s) exp_sample_q.push_back(smp);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("reset_phase", {8'h0, phase_out}, 32'h0);
    check("reset_sin_reset", {31'h0, sin_reset}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("prec", {28'h0, sin_prec}, 32'hA);

    // quarter-turn steps: 0, pi/2, pi, 3pi/2
    freq_inc = 24'h400000;
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h3FC90FDB, 32'h3F800000, 1'b1);
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h3FC90FDB, 32'hBF800000, 1'b1);
    wait_idle();

    // pi/4
    do_reset();
    freq_inc = 24'h200000;
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h3F490FDB, 32'h3F3504F3, 1'b1);
    wait_idle();

    // wrap: phase FFFFFF folds to f'=1, q=3
    do_reset();
    freq_inc = 24'hFFFFFF;
    tick(32'h00000000, 32'h00000000, 1'b1);
    check("wrap_phase1", {8'h0, phase_out}, 32'h00FFFFFF);
    tick(32'h34C90FDB, 32'hB4C90FDB, 1'b1);
    check("wrap_phase2", {8'h0, phase_out}, 32'h00FFFFFE);
    wait_idle();

    // tick during NORM
    do_reset();
    freq_inc = 24'h000010;
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h36C90FDB, 32'h36C90FDB, 1'b1);
    repeat (3) @(negedge clk);
    check("norm_busy", {31'h0, busy}, 32'h1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("overrun_pulse", {31'h0, overrun}, 32'h1);
    check("overrun_phase", {8'h0, phase_out}, 32'h00000030);
    @(negedge clk);
    check("overrun_clear", {31'h0, overrun}, 32'h0);
    wait_idle();
    repeat (4) @(negedge clk);
    check("no_extra_op", {31'h0, busy}, 32'h0);

    // stale done held on entry to WAIT
    do_reset();
    stub_stale = 1'b1;
    freq_inc = 24'h400000;
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h3FC90FDB, 32'h3F800000, 1'b1);
    wait_idle();
    stub_stale = 1'b0;

    // abort in WAIT
    do_reset();
    stub_lat = 10;
    freq_inc = 24'h200000;
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h3F490FDB, 32'h0, 1'b0);
    begin
      int n = 0;
      while (sin_reset && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) fail_now("wait_entry_timeout");
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_phase", {8'h0, phase_out}, 32'h0);
    check("abort_theta", sin_theta, 32'h0);
    check("abort_sin_reset", {31'h0, sin_reset}, 32'h1);
    check("abort_sample", sample_out, 32'h0);
    check("abort_valid", {31'h0, sample_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_overrun", {31'h0, overrun}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    stub_lat = 3;
    freq_inc = 24'h400000;
    @(negedge clk);
    tick(32'h00000000, 32'h00000000, 1'b1);
    tick(32'h3FC90FDB, 32'h3F800000, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("theta_queue_empty", exp_theta_q.size(), 32'h0);
    check("sample_queue_empty", exp_sample_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
